// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing generator: 640x480@60 defaults,
// sync polarity names and small elaboration/decode helpers.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int CLK_DIV_DEF  = 2;
  localparam int CW_DEF       = 10;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // True when value can be held in an unsigned field of the given width.
  function automatic bit fits_width(int value, int width);
    return (width >= 31) || (value < (1 << width));
  endfunction

  // Divider counter width; a divide-by-1 still needs a 1-bit register.
  function automatic int div_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // lo <= v < lo+len
  function automatic logic in_span(int v, int lo, int len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate divider: counts enabled system clocks and flags the last one of
// each CLK_DIV group, which is when the raster counters advance.
module vga_pix_div
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clock,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int DW = div_width(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_pix_div: CLK_DIV must be at least 1");
  end

  logic [DW-1:0] div_q, div_d;

  assign tick = enable && (div_q == DIV_LAST);

  // A frozen divider keeps its phase so a resume finishes the current pixel.
  always_comb begin
    div_d = div_q;
    if (enable) div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
  end

  always_ff @(posedge clock) begin
    if (!rst) div_q <= '0;
    else      div_q <= div_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel/line counters, active-video
// flag, H/V sync and line/frame start strobes, all registered and zero-skew.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic HS_POL   = SYNC_ACTIVE_LOW,
  parameter logic VS_POL   = SYNC_ACTIVE_LOW,
  parameter int   CLK_DIV  = CLK_DIV_DEF,
  parameter int   CW       = CW_DEF
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          enable,
  output logic [CW-1:0] x_pos,
  output logic [CW-1:0] y_pos,
  output logic          active_zone,
  output logic          h_sync,
  output logic          v_sync,
  output logic          pix_tick,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO   = H_ACTIVE + H_FP;
  localparam int VS_LO   = V_ACTIVE + V_FP;

  localparam logic [CW-1:0] X_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(V_TOTAL - 1);

  if (!fits_width(H_TOTAL - 1, CW)) begin : g_bad_h
    $error("vga_timing_gen: H_TOTAL-1 does not fit in CW bits");
  end
  if (!fits_width(V_TOTAL - 1, CW)) begin : g_bad_v
    $error("vga_timing_gen: V_TOTAL-1 does not fit in CW bits");
  end

  logic adv;

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clock  (clock),
    .rst    (rst),
    .enable (enable),
    .tick   (adv)
  );

  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          act_q, act_d;
  logic          hs_q, hs_d, vs_q, vs_d;
  logic          tick_q, ls_q, fs_q;
  logic          h_wrap, v_wrap;

  always_comb begin
    h_wrap = (x_q == X_LAST);
    v_wrap = (y_q == Y_LAST);
    x_d    = x_q;
    y_d    = y_q;
    if (adv) begin
      if (h_wrap) begin
        x_d = '0;
        y_d = v_wrap ? '0 : y_q + CW'(1);
      end else begin
        x_d = x_q + CW'(1);
      end
    end
  end

  // Decode from the next coordinates so levels land on the same edge as x/y.
  always_comb begin
    act_d = in_span(int'(x_d), 0, H_ACTIVE) && in_span(int'(y_d), 0, V_ACTIVE);
    hs_d  = in_span(int'(x_d), HS_LO, H_SYNC) ? HS_POL : ~HS_POL;
    vs_d  = in_span(int'(y_d), VS_LO, V_SYNC) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      x_q    <= '0;
      y_q    <= '0;
      act_q  <= 1'b1;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      tick_q <= 1'b0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      act_q  <= act_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      tick_q <= adv;
      ls_q   <= adv && h_wrap;
      fs_q   <= adv && h_wrap && v_wrap;
    end
  end

  assign x_pos       = x_q;
  assign y_pos       = y_q;
  assign active_zone = act_q;
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign pix_tick    = tick_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked against a raster
// model that derives every output from the count of enabled clocks since reset.
module tb_vga_timing_gen;

  typedef struct packed {
    int   ha, hf, hs, hb, va, vf, vs, vb, d;
    logic hp, vp;
  } cfg_t;

  typedef struct packed {
    logic [15:0] x, y;
    logic        act, hs, vs, tick, ls, fs;
  } obs_t;

  localparam cfg_t CA = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33,
                          d:2, hp:1'b0, vp:1'b0};
  localparam cfg_t CB = '{ha:4, hf:1, hs:2, hb:1, va:3, vf:1, vs:1, vb:1,
                          d:1, hp:1'b1, vp:1'b0};
  localparam cfg_t CC = '{ha:8, hf:2, hs:3, hb:2, va:5, vf:1, vs:2, vb:1,
                          d:3, hp:1'b0, vp:1'b1};

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic rst_a, en_a, rst_b, en_b, rst_c, en_c;
  logic [9:0] x_a, y_a;
  logic [3:0] x_b, y_b;
  logic [4:0] x_c, y_c;
  logic act_a, hs_a, vs_a, pt_a, ls_a, fs_a;
  logic act_b, hs_b, vs_b, pt_b, ls_b, fs_b;
  logic act_c, hs_c, vs_c, pt_c, ls_c, fs_c;

  vga_timing_gen u_a (
    .clock(clk), .rst(rst_a), .enable(en_a), .x_pos(x_a), .y_pos(y_a),
    .active_zone(act_a), .h_sync(hs_a), .v_sync(vs_a), .pix_tick(pt_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(CB.ha), .H_FP(CB.hf), .H_SYNC(CB.hs), .H_BP(CB.hb),
    .V_ACTIVE(CB.va), .V_FP(CB.vf), .V_SYNC(CB.vs), .V_BP(CB.vb),
    .HS_POL(CB.hp), .VS_POL(CB.vp), .CLK_DIV(CB.d), .CW(4)
  ) u_b (
    .clock(clk), .rst(rst_b), .enable(en_b), .x_pos(x_b), .y_pos(y_b),
    .active_zone(act_b), .h_sync(hs_b), .v_sync(vs_b), .pix_tick(pt_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(CC.ha), .H_FP(CC.hf), .H_SYNC(CC.hs), .H_BP(CC.hb),
    .V_ACTIVE(CC.va), .V_FP(CC.vf), .V_SYNC(CC.vs), .V_BP(CC.vb),
    .HS_POL(CC.hp), .VS_POL(CC.vp), .CLK_DIV(CC.d), .CW(5)
  ) u_c (
    .clock(clk), .rst(rst_c), .enable(en_c), .x_pos(x_c), .y_pos(y_c),
    .active_zone(act_c), .h_sync(hs_c), .v_sync(vs_c), .pix_tick(pt_c),
    .line_start(ls_c), .frame_start(fs_c)
  );

  // Pixel index = enabled clocks / divider; coordinates fall out by div/mod.
  function automatic obs_t model(cfg_t c, int n, logic tk);
    obs_t o;
    int ht, vt, p, x, y;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    p  = n / c.d;
    x  = p % ht;
    y  = (p / ht) % vt;
    o.x    = 16'(x);
    o.y    = 16'(y);
    o.act  = (x < c.ha) && (y < c.va);
    o.hs   = (x >= c.ha + c.hf && x < c.ha + c.hf + c.hs) ? c.hp : ~c.hp;
    o.vs   = (y >= c.va + c.vf && y < c.va + c.vf + c.vs) ? c.vp : ~c.vp;
    o.tick = tk;
    o.ls   = tk && (x == 0);
    o.fs   = tk && (x == 0) && (y == 0);
    return o;
  endfunction

  int n_a = 0, n_b = 0, n_c = 0;
  logic tk_a = 1'b0, tk_b = 1'b0, tk_c = 1'b0;

  always @(posedge clk) begin
    if (!rst_a) begin n_a <= 0; tk_a <= 1'b0; end
    else if (en_a) begin n_a <= n_a + 1; tk_a <= ((n_a + 1) % CA.d) == 0; end
    else tk_a <= 1'b0;
  end
  always @(posedge clk) begin
    if (!rst_b) begin n_b <= 0; tk_b <= 1'b0; end
    else if (en_b) begin n_b <= n_b + 1; tk_b <= ((n_b + 1) % CB.d) == 0; end
    else tk_b <= 1'b0;
  end
  always @(posedge clk) begin
    if (!rst_c) begin n_c <= 0; tk_c <= 1'b0; end
    else if (en_c) begin n_c <= n_c + 1; tk_c <= ((n_c + 1) % CC.d) == 0; end
    else tk_c <= 1'b0;
  end

  obs_t o_a, o_b, o_c, e_a, e_b, e_c;
  assign o_a = {6'd0, x_a, 6'd0, y_a, act_a, hs_a, vs_a, pt_a, ls_a, fs_a};
  assign o_b = {12'd0, x_b, 12'd0, y_b, act_b, hs_b, vs_b, pt_b, ls_b, fs_b};
  assign o_c = {11'd0, x_c, 11'd0, y_c, act_c, hs_c, vs_c, pt_c, ls_c, fs_c};
  assign e_a = model(CA, n_a, tk_a);
  assign e_b = model(CB, n_b, tk_b);
  assign e_c = model(CC, n_c, tk_c);

  function automatic obs_t reset_obs(cfg_t c);
    return '{x:16'd0, y:16'd0, act:1'b1, hs:~c.hp, vs:~c.vp,
             tick:1'b0, ls:1'b0, fs:1'b0};
  endfunction

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    #15;
    checks++; if (o_a !== reset_obs(CA)) begin errors++; $display("FAIL reset_a: got %h want %h", o_a, reset_obs(CA)); end
    checks++; if (o_b !== reset_obs(CB)) begin errors++; $display("FAIL reset_b: got %h want %h", o_b, reset_obs(CB)); end
    checks++; if (o_c !== reset_obs(CC)) begin errors++; $display("FAIL reset_c: got %h want %h", o_c, reset_obs(CC)); end
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (x_a !== 10'd0 || pt_a !== 1'b0) begin errors++; $display("FAIL first_edge_a: got x=%0d tick=%b want x=0 tick=0", x_a, pt_a); end
    checks++; if (x_b !== 4'd1 || pt_b !== 1'b1) begin errors++; $display("FAIL first_edge_b: got x=%0d tick=%b want x=1 tick=1", x_b, pt_b); end
    @(negedge clk);
    checks++; if (x_a !== 10'd1 || pt_a !== 1'b1 || ls_a !== 1'b0) begin errors++; $display("FAIL second_edge_a: got x=%0d tick=%b ls=%b want x=1 tick=1 ls=0", x_a, pt_a, ls_a); end
  endtask

  task automatic test_line();
    int f1 = -1, f2 = -1, hs_low = 0, hs_bad = 0, act_bad = 0;
    for (int cyc = 0; cyc < 3400; cyc++) begin
      @(negedge clk);
      checks++; if (o_a !== e_a) begin errors++; $display("FAIL line_model cyc %0d: got %h want %h", cyc, o_a, e_a); end
      if (ls_a) begin
        if (f1 < 0) f1 = cyc;
        else if (f2 < 0) f2 = cyc;
      end
      if (f1 >= 0 && f2 < 0 && !hs_a) hs_low++;
      if (hs_a !== !(x_a >= 656 && x_a <= 751)) hs_bad++;
      if (act_a && x_a >= 640) act_bad++;
    end
    checks++; if (f2 - f1 != 1600) begin errors++; $display("FAIL line_period: got %0d want 1600", f2 - f1); end
    checks++; if (hs_low != 192) begin errors++; $display("FAIL hsync_width: got %0d want 192", hs_low); end
    checks++; if (hs_bad != 0) begin errors++; $display("FAIL hsync_window: got %0d bad clocks want 0", hs_bad); end
    checks++; if (act_bad != 0) begin errors++; $display("FAIL active_h_blank: got %0d bad clocks want 0", act_bad); end
  endtask

  task automatic test_enable_freeze();
    logic [9:0] sx, sy;
    logic shs, svs;
    int waited = 0;
    while (!(x_a == 10'd100 && pt_a) && waited < 3300) begin @(negedge clk); waited++; end
    checks++; if (waited >= 3300) begin errors++; $display("FAIL freeze_reach_x100: got timeout want x=100"); end
    sx = x_a; sy = y_a; shs = hs_a; svs = vs_a;
    en_a = 1'b0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      checks++;
      if ({x_a, y_a, hs_a, vs_a, pt_a, ls_a, fs_a} !== {sx, sy, shs, svs, 3'b000}) begin
        errors++; $display("FAIL freeze_hold %0d: got x=%0d y=%0d hs=%b vs=%b strobes=%b%b%b want x=%0d y=%0d hs=%b vs=%b strobes=000",
                            i, x_a, y_a, hs_a, vs_a, pt_a, ls_a, fs_a, sx, sy, shs, svs);
      end
    end
    en_a = 1'b1;
    @(negedge clk);
    checks++; if (x_a !== 10'd100 || pt_a !== 1'b0) begin errors++; $display("FAIL resume_1: got x=%0d tick=%b want x=100 tick=0", x_a, pt_a); end
    @(negedge clk);
    checks++; if (x_a !== 10'd101 || pt_a !== 1'b1) begin errors++; $display("FAIL resume_2: got x=%0d tick=%b want x=101 tick=1", x_a, pt_a); end
    checks++; if (o_a !== e_a) begin errors++; $display("FAIL resume_model: got %h want %h", o_a, e_a); end
  endtask

  task automatic test_small_frame();
    int f1 = -1, f2 = -1, act_cnt = 0, hs_cnt = 0, hs_bad = 0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(negedge clk);
      checks++; if (o_b !== e_b) begin errors++; $display("FAIL small_model cyc %0d: got %h want %h", cyc, o_b, e_b); end
      if (fs_b) begin
        if (f1 < 0) f1 = cyc;
        else if (f2 < 0) f2 = cyc;
      end
      if (f1 >= 0 && f2 < 0) begin
        if (act_b) act_cnt++;
        if (hs_b) hs_cnt++;
      end
      if (hs_b !== (x_b == 4'd5 || x_b == 4'd6)) hs_bad++;
    end
    checks++; if (f2 - f1 != 48) begin errors++; $display("FAIL small_frame_period: got %0d want 48", f2 - f1); end
    checks++; if (act_cnt != 12) begin errors++; $display("FAIL small_active_count: got %0d want 12", act_cnt); end
    checks++; if (hs_cnt != 12) begin errors++; $display("FAIL small_hsync_count: got %0d want 12", hs_cnt); end
    checks++; if (hs_bad != 0) begin errors++; $display("FAIL small_hsync_window: got %0d bad clocks want 0", hs_bad); end
  endtask

  task automatic test_frame();
    int f1 = -1, f2 = -1, vs_cnt = 0, vs_bad = 0, act_bad = 0, wrap_bad = 0, wraps = 0;
    logic [4:0] prev_y;
    prev_y = y_c;
    for (int cyc = 0; cyc < 900; cyc++) begin
      @(negedge clk);
      checks++; if (o_c !== e_c) begin errors++; $display("FAIL frame_model cyc %0d: got %h want %h", cyc, o_c, e_c); end
      if (fs_c) begin
        if (f1 < 0) f1 = cyc;
        else if (f2 < 0) f2 = cyc;
        wraps++;
        if (!(prev_y == 5'd8 && y_c == 5'd0 && x_c == 5'd0)) wrap_bad++;
      end else if (y_c != prev_y && y_c != prev_y + 5'd1) wrap_bad++;
      if (f1 >= 0 && f2 < 0 && vs_c) vs_cnt++;
      if (vs_c !== (y_c == 5'd6 || y_c == 5'd7)) vs_bad++;
      if (act_c && y_c >= 5'd5) act_bad++;
      prev_y = y_c;
    end
    checks++; if (f2 - f1 != 405) begin errors++; $display("FAIL frame_period: got %0d want 405", f2 - f1); end
    checks++; if (vs_cnt != 90) begin errors++; $display("FAIL vsync_width: got %0d want 90", vs_cnt); end
    checks++; if (vs_bad != 0) begin errors++; $display("FAIL vsync_window: got %0d bad clocks want 0", vs_bad); end
    checks++; if (act_bad != 0) begin errors++; $display("FAIL active_v_blank: got %0d bad clocks want 0", act_bad); end
    checks++; if (wrap_bad != 0 || wraps < 2) begin errors++; $display("FAIL y_wrap: got %0d bad, %0d wraps want 0 bad, >=2 wraps", wrap_bad, wraps); end
  endtask

  task automatic test_rst_pulse();
    int waited = 0;
    while (!(x_a == 10'd700 && y_a != 10'd0) && waited < 3300) begin @(negedge clk); waited++; end
    checks++; if (waited >= 3300) begin errors++; $display("FAIL rst_reach_a: got timeout want x=700"); end
    rst_a = 1'b0;
    @(negedge clk);
    checks++; if (o_a !== reset_obs(CA)) begin errors++; $display("FAIL rst_pulse_a: got %h want %h", o_a, reset_obs(CA)); end
    rst_a = 1'b1;
    @(negedge clk);
    checks++; if (x_a !== 10'd0 || pt_a !== 1'b0 || ls_a !== 1'b0 || fs_a !== 1'b0) begin errors++; $display("FAIL rst_release_a: got x=%0d strobes=%b%b%b want x=0 strobes=000", x_a, pt_a, ls_a, fs_a); end
    waited = 0;
    while (!(x_c == 5'd10 && y_c == 5'd3) && waited < 500) begin @(negedge clk); waited++; end
    checks++; if (waited >= 500) begin errors++; $display("FAIL rst_reach_c: got timeout want x=10 y=3"); end
    rst_c = 1'b0;
    @(negedge clk);
    checks++; if (o_c !== reset_obs(CC)) begin errors++; $display("FAIL rst_pulse_c: got %h want %h", o_c, reset_obs(CC)); end
    rst_c = 1'b1;
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      checks++; if (o_a !== e_a) begin errors++; $display("FAIL rand_a cyc %0d: got %h want %h", cyc, o_a, e_a); end
      checks++; if (o_b !== e_b) begin errors++; $display("FAIL rand_b cyc %0d: got %h want %h", cyc, o_b, e_b); end
      checks++; if (o_c !== e_c) begin errors++; $display("FAIL rand_c cyc %0d: got %h want %h", cyc, o_c, e_c); end
      en_a  = ($urandom_range(0, 4) != 0);
      en_b  = ($urandom_range(0, 4) != 0);
      en_c  = ($urandom_range(0, 4) != 0);
      rst_a = ($urandom_range(0, 299) != 0);
      rst_b = ($urandom_range(0, 99) != 0);
      rst_c = ($urandom_range(0, 149) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_enable_freeze();
    test_small_frame();
    test_frame();
    test_rst_pulse();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
